// File: rtl/imem_burst_model.sv
// rtl/imem_burst_model.sv - wait-state instruction ROM serving wrapping (critical-word-first) line fills
// Contents come from ROM_INIT (word i at bits [i*WIDTH +: WIDTH]); beats, last and data are registered.
module imem_burst_model #(
  parameter int WIDTH       = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2,
  parameter int BURST       = 4,
  parameter logic [DEPTH_WORDS*WIDTH-1:0] ROM_INIT = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req,
  input  logic [WIDTH-1:0] addr,
  output logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             last,
  output logic             busy,
  output logic             err,
  output logic [31:0]      req_count,
  output logic [31:0]      stall_count
);
  localparam int IW = WIDTH - 2;
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [IW-1:0] BMASK     = IW'(BURST - 1);
  localparam logic [IW-1:0] DEPTH_IW  = IW'(DEPTH_WORDS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);
  localparam logic [3:0]    LAT4      = 4'(LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    word_q, word_d;
  logic [3:0]       wait_q, wait_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic             ready_q, ready_d;
  logic             last_q, last_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [31:0]      req_cnt_q, req_cnt_d;
  logic [31:0]      stall_cnt_q, stall_cnt_d;

  logic [WIDTH-1:0] rom [DEPTH_WORDS];
  for (genvar g = 0; g < DEPTH_WORDS; g++) begin : g_rom
    assign rom[g] = ROM_INIT[g*WIDTH +: WIDTH];
  end

  // Beat k reads the aligned block base plus (critical offset + k) mod BURST.
  logic [IW-1:0] beat_idx;
  logic          in_range;
  logic          unused_addr_lsb;
  assign beat_idx        = (word_q & ~BMASK) | ((word_q + {{(IW-BW){1'b0}}, beat_q}) & BMASK);
  assign in_range        = beat_idx < DEPTH_IW;
  assign unused_addr_lsb = ^addr[1:0];

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    wait_d      = wait_q;
    beat_d      = beat_q;
    ready_d     = 1'b0;
    last_d      = 1'b0;
    data_d      = '0;
    err_d       = err_q;
    req_cnt_d   = req_cnt_q;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          word_d    = addr[WIDTH-1:2];
          beat_d    = '0;
          wait_d    = LAT4;
          req_cnt_d = sat_inc(req_cnt_q);
          state_d   = (LATENCY == 0) ? S_BURST : S_WAIT;
        end
      end
      S_WAIT: begin
        stall_cnt_d = sat_inc(stall_cnt_q);
        wait_d      = wait_q - 4'd1;
        if (wait_q <= 4'd1) state_d = S_BURST;
      end
      S_BURST: begin
        ready_d = 1'b1;
        data_d  = in_range ? rom[beat_idx[AW-1:0]] : '0;
        if (!in_range) err_d = 1'b1;
        last_d  = (beat_q == LAST_BEAT);
        beat_d  = beat_q + 1'b1;
        if (beat_q == LAST_BEAT) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      word_q      <= '0;
      wait_q      <= '0;
      beat_q      <= '0;
      ready_q     <= 1'b0;
      last_q      <= 1'b0;
      data_q      <= '0;
      err_q       <= 1'b0;
      req_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      wait_q      <= wait_d;
      beat_q      <= beat_d;
      ready_q     <= ready_d;
      last_q      <= last_d;
      data_q      <= data_d;
      err_q       <= err_d;
      req_cnt_q   <= req_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ready       = ready_q;
  assign data        = data_q;
  assign last        = last_q;
  assign busy        = (state_q != S_IDLE);
  assign err         = err_q;
  assign req_count   = req_cnt_q;
  assign stall_count = stall_cnt_q;
endmodule
